// File: rtl/ksa.sv
// ksa: RC4 key-scheduling pass over a 256x8 single-port S RAM.
// On an accepted start it permutes the identity-loaded RAM.
// For i = 0..255 it computes j = j + S[i] + key[i mod KEY_BYTES],
// then swaps S[i] and S[j].
// Optional feature macro: KSA_SKIP_SELF_SWAP_EN. When defined, an index
// whose new j equals i skips its read/write of S[j] and takes 2 cycles.
module ksa #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_I,
    S_LD_I,
    S_RD_J,
    S_LD_J,
    S_WR_I,
    S_WR_J
  } state_t;

  state_t                 state, next_state;
  logic [7:0]             i, j, si, sj;
  logic [KW-1:0]          kidx;
  logic [8*KEY_BYTES-1:0] key_q;

  logic [7:0] key_byte;
  logic [7:0] j_sum;
  logic       last_i;
  logic       self_skip;
  logic       index_done;

  // Select key byte kidx; byte 0 is the most-significant byte of the key.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx == KW'(b)) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  assign j_sum  = j + rddata + key_byte;
  assign last_i = (i == 8'hFF);

`ifdef KSA_SKIP_SELF_SWAP_EN
  assign self_skip = (state == S_LD_I) && (j_sum == i);
`else
  assign self_skip = 1'b0;
`endif

  // The current index is finished after the second write, or when a self-swap is skipped.
  assign index_done = (state == S_WR_J) || self_skip;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so all registers update
  // together from pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decode: six one-cycle steps per index, or two when a self-swap is skipped.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (en) next_state = S_RD_I;
      S_RD_I: next_state = S_LD_I;
      S_LD_I: begin
        if (self_skip) next_state = last_i ? S_IDLE : S_RD_I;
        else           next_state = S_RD_J;
      end
      S_RD_J: next_state = S_LD_J;
      S_LD_J: next_state = S_WR_I;
      S_WR_I: next_state = S_WR_J;
      S_WR_J: next_state = last_i ? S_IDLE : S_RD_I;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath registers: key capture, index counters and the two swap operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i     <= '0;
      j     <= '0;
      kidx  <= '0;
      si    <= '0;
      sj    <= '0;
      key_q <= '0;
    end else begin
      if (state == S_IDLE && en) begin
        key_q <= key;
        i     <= '0;
        j     <= '0;
        kidx  <= '0;
      end
      if (state == S_LD_I) begin
        si <= rddata;
        j  <= j_sum;
      end
      if (state == S_LD_J) sj <= rddata;
      if (index_done && !last_i) begin
        i    <= i + 8'd1;
        kidx <= (kidx == KW'(KEY_BYTES-1)) ? '0 : kidx + KW'(1);
      end
    end
  end

  // RAM port and handshake outputs, decoded purely from registered state.
  always_comb begin
    rdy    = 1'b0;
    addr   = '0;
    wrdata = '0;
    wren   = 1'b0;
    unique case (state)
      S_IDLE: rdy = 1'b1;
      S_RD_I, S_LD_I: addr = i;
      S_RD_J, S_LD_J: addr = j;
      S_WR_I: begin
        addr   = i;
        wrdata = sj;
        wren   = 1'b1;
      end
      S_WR_J: begin
        addr   = j;
        wrdata = si;
        wren   = 1'b1;
      end
      default: rdy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ksa.sv
// tb_ksa: self-checking bench for ksa with a behavioural S RAM and an RC4-KSA model.
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  logic [7:0]  mem [256];
  logic        load_identity;
  logic [7:0]  ref_s [256];

  int n_checks = 0;
  int n_fail   = 0;

  ksa #(.KEY_BYTES(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  always #5 clk = ~clk;

  // Single-port S RAM with one-cycle read latency and an identity preload request.
  always @(posedge clk) begin
    if (load_identity) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
    rddata <= mem[addr];
  end

  typedef struct {
    logic [7:0] addr;
    logic       wren;
    logic [7:0] wrdata;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plain RC4 key schedule applied to ref_s in place; counts indices where j == i.
  task automatic model_ksa(input logic [23:0] k, output int swaps);
    int jj;
    int kb;
    logic [7:0] t;
    jj = 0;
    swaps = 0;
    for (int ii = 0; ii < 256; ii++) begin
      kb = int'((k >> (8 * (2 - (ii % 3)))) & 24'hFF);
      jj = (jj + int'(ref_s[ii]) + kb) % 256;
      if (jj == ii) swaps++;
      t         = ref_s[ii];
      ref_s[ii] = ref_s[jj];
      ref_s[jj] = t;
    end
  endtask

  function automatic int exp_len(input int swaps);
`ifdef KSA_SKIP_SELF_SWAP_EN
    return 1536 - 4 * swaps;
`else
    return 1536 + 0 * swaps;
`endif
  endfunction

  task automatic preload;
    load_identity = 1'b1;
    @(negedge clk);
    load_identity = 1'b0;
    for (int k = 0; k < 256; k++) ref_s[k] = 8'(k);
  endtask

  // Leaves the bench at the first post-start sample point (the RD_I cycle for i=0).
  task automatic start_run(input logic [23:0] k, input logic hold_en);
    key = k;
    en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold_en) en = 1'b0;
  endtask

  // Counts busy cycles from the current (uncounted) sample until rdy returns.
  task automatic wait_done(input int start, output int cycles);
    cycles = start;
    while (rdy !== 1'b1 && cycles < 3000) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic check_ram(input string name);
    for (int k = 0; k < 256; k++) check(name, 32'(mem[k]), 32'(ref_s[k]));
  endtask

  initial begin
    int cycles;
    int swaps;
    int swaps2;
    logic [23:0] rk;
    logic        no_wr;

`ifdef KSA_SKIP_SELF_SWAP_EN
    vecs = '{'{8'd0, 1'b0, 8'd0}, '{8'd0, 1'b0, 8'd0},
             '{8'd1, 1'b0, 8'd0}, '{8'd1, 1'b0, 8'd0},
             '{8'd2, 1'b0, 8'd0}, '{8'd2, 1'b0, 8'd0},
             '{8'd3, 1'b0, 8'd0}, '{8'd3, 1'b0, 8'd0},
             '{8'd2, 1'b1, 8'd3}, '{8'd3, 1'b1, 8'd2},
             '{8'd3, 1'b0, 8'd0}, '{8'd3, 1'b0, 8'd0}};
    rk = 24'h000000;
`else
    vecs = '{'{8'd0, 1'b0, 8'd0}, '{8'd0, 1'b0, 8'd0},
             '{8'd0, 1'b0, 8'd0}, '{8'd0, 1'b0, 8'd0},
             '{8'd0, 1'b1, 8'd0}, '{8'd0, 1'b1, 8'd0},
             '{8'd1, 1'b0, 8'd0}, '{8'd1, 1'b0, 8'd0},
             '{8'd4, 1'b0, 8'd0}, '{8'd4, 1'b0, 8'd0},
             '{8'd1, 1'b1, 8'd4}, '{8'd4, 1'b1, 8'd1}};
    rk = 24'h00033C;
`endif

    rst = 1'b1;
    en = 1'b0;
    key = '0;
    load_identity = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rdy", 32'(rdy), 32'd1);
    check("reset_wren", 32'(wren), 32'd0);
    check("reset_addr", 32'(addr), 32'd0);
    check("reset_wrdata", 32'(wrdata), 32'd0);
    rst = 1'b0;

    // Idle with en low: nothing is written and rdy stays high.
    no_wr = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (wren !== 1'b0 || rdy !== 1'b1) no_wr = 1'b0;
    end
    check("idle_quiet", 32'(no_wr), 32'd1);

    // Cycle-exact address/write sequence for the first 12 busy cycles.
    preload();
    model_ksa(rk, swaps);
    start_run(rk, 1'b0);
    for (int v = 0; v < 12; v++) begin
      check($sformatf("vec%0d_addr", v), 32'(addr), 32'(vecs[v].addr));
      check($sformatf("vec%0d_wren", v), 32'(wren), 32'(vecs[v].wren));
      if (vecs[v].wren) check($sformatf("vec%0d_wrdata", v), 32'(wrdata), 32'(vecs[v].wrdata));
      check($sformatf("vec%0d_rdy", v), 32'(rdy), 32'd0);
      @(negedge clk);
    end
    wait_done(12, cycles);
    check("first_run_len", 32'(cycles), 32'(exp_len(swaps)));
    check_ram("first_run_ram");

    // Randomised keys against the model.
    for (int r = 0; r < 3; r++) begin
      rk = 24'($urandom);
      preload();
      model_ksa(rk, swaps);
      start_run(rk, 1'b0);
      wait_done(0, cycles);
      check($sformatf("rand%0d_len", r), 32'(cycles), 32'(exp_len(swaps)));
      check_ram($sformatf("rand%0d_ram", r));
    end

    // en pulse and key change mid-run are ignored.
    rk = 24'h00033C;
    preload();
    model_ksa(rk, swaps);
    start_run(rk, 1'b0);
    repeat (99) @(negedge clk);
    en  = 1'b1;
    key = 24'hA5C3_5A;
    @(negedge clk);
    en  = 1'b0;
    wait_done(100, cycles);
    check("keychg_len", 32'(cycles), 32'(exp_len(swaps)));
    check_ram("keychg_ram");

    // Reset mid-run at cycle 700, then a clean restart.
    preload();
    start_run(24'h123456, 1'b0);
    repeat (699) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_rdy", 32'(rdy), 32'd1);
    check("midrst_wren", 32'(wren), 32'd0);
    check("midrst_addr", 32'(addr), 32'd0);
    check("midrst_wrdata", 32'(wrdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", 32'(rdy), 32'd1);
    rk = 24'h00033C;
    preload();
    model_ksa(rk, swaps);
    start_run(rk, 1'b0);
    check("restart_rdy", 32'(rdy), 32'd0);
    check("restart_addr", 32'(addr), 32'd0);
    wait_done(0, cycles);
    check("restart_len", 32'(cycles), 32'(exp_len(swaps)));
    check_ram("restart_ram");

    // en held high: a second run starts right after rdy returns and permutes again.
    rk = 24'h0F1E2D;
    preload();
    model_ksa(rk, swaps);
    model_ksa(rk, swaps2);
    start_run(rk, 1'b1);
    wait_done(0, cycles);
    check("b2b_len1", 32'(cycles), 32'(exp_len(swaps)));
    check("b2b_rdy_back", 32'(rdy), 32'd1);
    @(negedge clk);
    en = 1'b0;
    check("b2b_restart_rdy", 32'(rdy), 32'd0);
    check("b2b_restart_addr", 32'(addr), 32'd0);
    wait_done(0, cycles);
    check("b2b_len2", 32'(cycles), 32'(exp_len(swaps2)));
    check_ram("b2b_ram");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
